// File: rtl/gtech_serial_add_pkg.sv
// gtech_serial_add_pkg
//   Shared definitions for the bit-serial adder slice:
//   - state_t     : FSM state encoding (IDLE, RUN, DONE)
//   - cnt_width() : bit counter width, clog2(WIDTH+1), so WIDTH itself fits
//   - WIDTH_MIN / WIDTH_MAX : legal operand width range (1..64)
//   Optional feature macro used by the slice: GTECH_SERIAL_ADD_CIN_EN.
package gtech_serial_add_pkg;

    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must hold the value WIDTH (saturation point), hence WIDTH+1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 1) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/gtech_serial_add_if.sv
// gtech_serial_add_if
//   Request/result bundle of the bit-serial adder.
//   Parameter: WIDTH - operand/result width (1..64).
//   Signals:
//     i_start        request, sampled by the adder in IDLE/DONE only
//     i_a, i_b       operands, captured on an accepted request
//     i_cin          carry-in (only when GTECH_SERIAL_ADD_CIN_EN is defined)
//     o_busy         high while the adder is in RUN
//     o_done         one-cycle result-valid pulse
//     o_s, o_cout    registered sum / carry-out, held until the next result
//   Modports: master (requester side), slave (adder side).
//   Macro: GTECH_SERIAL_ADD_CIN_EN adds i_cin.
interface gtech_serial_add_if #(
    parameter int unsigned WIDTH = 8
);

    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
`ifdef GTECH_SERIAL_ADD_CIN_EN
    logic             i_cin;
`endif
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_s;
    logic             o_cout;

    modport master (
`ifdef GTECH_SERIAL_ADD_CIN_EN
        output i_cin,
`endif
        output i_start, i_a, i_b,
        input  o_busy, o_done, o_s, o_cout
    );

    modport slave (
`ifdef GTECH_SERIAL_ADD_CIN_EN
        input  i_cin,
`endif
        input  i_start, i_a, i_b,
        output o_busy, o_done, o_s, o_cout
    );

endinterface

// File: rtl/gtech_serial_add_bit.sv
// gtech_serial_add_bit
//   Combinational one-bit full-add cell built from two half-add stages and
//   an OR of their carries. This is the only arithmetic in the adder.
//   Ports:
//     i_a, i_b, i_ci  operand bits and carry-in
//     o_s, o_co       sum and carry-out
module gtech_serial_add_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    // first half-add: a + b
    assign w_s1 = i_a ^ i_b;
    assign w_c1 = i_a & i_b;

    // second half-add: partial sum + carry-in
    assign o_s  = w_s1 ^ i_ci;
    assign w_c2 = w_s1 & i_ci;

    // the two half-add carries can never both be 1
    assign o_co = w_c1 | w_c2;

endmodule

// File: rtl/gtech_serial_add.sv
// gtech_serial_add
//   Bit-serial unsigned adder: one full-add cell with a registered carry,
//   one bit per clock LSB first. {o_cout, o_s} = A + B (+ CIN).
//   Latency: accepted on edge T0, o_done high in the cycle after T0+WIDTH.
//   Parameter: WIDTH - operand/result width, legal range 1..64.
//   Ports:
//     i_clk  rising-edge clock
//     i_rst  synchronous active-high reset (priority over start)
//     bus    gtech_serial_add_if.slave request/result bundle
//   Macro: GTECH_SERIAL_ADD_CIN_EN - carry register loads i_cin on accept;
//          otherwise it loads 0 and bit 0 is effectively a half add.
module gtech_serial_add
    import gtech_serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    gtech_serial_add_if.slave bus
);

    localparam int unsigned    CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;

    logic             w_s;
    logic             w_co;
    logic             w_cin;
    logic [WIDTH-1:0] w_sum_next;

`ifdef GTECH_SERIAL_ADD_CIN_EN
    assign w_cin = bus.i_cin;
`else
    assign w_cin = 1'b0;
`endif

    gtech_serial_add_bit u_bit (
        .i_a  (r_a[0]),
        .i_b  (r_b[0]),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    // New sum bit enters at the MSB; written this way so WIDTH=1 needs no
    // special-case slice.
    always_comb begin
        w_sum_next            = r_sum >> 1;
        w_sum_next[WIDTH-1]   = w_s;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.i_start) begin
                        r_a     <= bus.i_a;
                        r_b     <= bus.i_b;
                        r_carry <= w_cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_sum   <= w_sum_next;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_co;
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    // last bit-edge: publish the result straight from the
                    // cell outputs so S/COUT update together with DONE
                    if (r_cnt == CNT_LAST) begin
                        r_s     <= w_sum_next;
                        r_cout  <= w_co;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;
    assign bus.o_s    = r_s;
    assign bus.o_cout = r_cout;

endmodule

// File: tb/tb_gtech_serial_add.sv
// tb_gtech_serial_add
//   Directed bench for gtech_serial_add: a WIDTH=8 instance for the main
//   sequences and a WIDTH=1 instance for the single-bit corner.
module tb_gtech_serial_add;
    import gtech_serial_add_pkg::*;

    logic clk;
    logic rst;

    int unsigned n_cmp;
    int unsigned n_err;

    gtech_serial_add_if #(.WIDTH(8)) bus8 ();
    gtech_serial_add_if #(.WIDTH(1)) bus1 ();

    gtech_serial_add #(.WIDTH(8)) dut8 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus8.slave)
    );

    gtech_serial_add #(.WIDTH(1)) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One START pulse on the 8-bit unit; checks BUSY length, DONE timing,
    // result, hold of the previous result during RUN, and DONE pulse width.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] es, input logic ec,
                         input logic [7:0] prev_s, input logic prev_c);
        int unsigned k;
        int unsigned nb;
        logic held;
        bus8.i_start = 1'b1;
        bus8.i_a     = a;
        bus8.i_b     = b;
`ifdef GTECH_SERIAL_ADD_CIN_EN
        bus8.i_cin   = cin;
`endif
        @(posedge clk); #1;
        bus8.i_start = 1'b0;
        bus8.i_a     = 8'($urandom);
        bus8.i_b     = 8'($urandom);
        k = 0; nb = 0; held = 1'b1;
        while (bus8.o_done !== 1'b1 && k < 30) begin
            if (bus8.o_busy === 1'b1) nb++;
            if (bus8.o_s !== prev_s || bus8.o_cout !== prev_c) held = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        // DONE seen just after edge T0+8, i.e. sampled on edge T0+9
        check({tag, "_done_edges"}, 64'(k), 64'd8);
        check({tag, "_busy_cycles"}, 64'(nb), 64'd8);
        check({tag, "_held"}, 64'(held), 64'd1);
        check({tag, "_s"}, 64'(bus8.o_s), 64'(es));
        check({tag, "_cout"}, 64'(bus8.o_cout), 64'(ec));
        check({tag, "_busy_at_done"}, 64'(bus8.o_busy), 64'd0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(bus8.o_done), 64'd0);
        check({tag, "_s_kept"}, 64'(bus8.o_s), 64'(es));
    endtask

    logic [7:0]  b2b_a [3];
    logic [7:0]  b2b_b [3];
    logic [7:0]  b2b_s [3];
    logic        b2b_c [3];

    initial begin
        int unsigned k;
        int unsigned ndone;
        logic [7:0]  cap_s;
        logic        cap_c;

        n_cmp = 0;
        n_err = 0;
        b2b_a = '{8'h80, 8'h7F, 8'h00};
        b2b_b = '{8'h80, 8'h01, 8'h00};
        b2b_s = '{8'h00, 8'h80, 8'h00};
        b2b_c = '{1'b1, 1'b0, 1'b0};

        rst = 1'b1;
        bus8.i_start = 1'b0; bus8.i_a = '0; bus8.i_b = '0;
        bus1.i_start = 1'b0; bus1.i_a = '0; bus1.i_b = '0;
`ifdef GTECH_SERIAL_ADD_CIN_EN
        bus8.i_cin = 1'b0;
        bus1.i_cin = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        check("rst_busy", 64'(bus8.o_busy), 64'd0);
        check("rst_done", 64'(bus8.o_done), 64'd0);
        check("rst_s", 64'(bus8.o_s), 64'd0);
        check("rst_cout", 64'(bus8.o_cout), 64'd0);
        check("rst1_s", 64'(bus1.o_s), 64'd0);

        // basic sums
        do_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 8'h00, 1'b0);
        do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h96, 1'b0);

        // START during RUN is ignored
        bus8.i_start = 1'b1; bus8.i_a = 8'h01; bus8.i_b = 8'h02;
        @(posedge clk); #1;
        bus8.i_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus8.i_start = 1'b1; bus8.i_a = 8'h11; bus8.i_b = 8'h22;
        @(posedge clk); #1;
        bus8.i_start = 1'b0;
        ndone = 0; cap_s = 8'hXX; cap_c = 1'bx;
        for (int i = 0; i < 20; i++) begin
            if (bus8.o_done === 1'b1) begin
                ndone++;
                cap_s = bus8.o_s;
                cap_c = bus8.o_cout;
            end
            @(posedge clk); #1;
        end
        check("ign_ndone", 64'(ndone), 64'd1);
        check("ign_s", 64'(cap_s), 64'h03);
        check("ign_cout", 64'(cap_c), 64'd0);

        // reset in the middle of RUN
        bus8.i_start = 1'b1; bus8.i_a = 8'hF0; bus8.i_b = 8'h0F;
        @(posedge clk); #1;
        bus8.i_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_busy", 64'(bus8.o_busy), 64'd0);
        check("mrst_done", 64'(bus8.o_done), 64'd0);
        check("mrst_s", 64'(bus8.o_s), 64'd0);
        check("mrst_cout", 64'(bus8.o_cout), 64'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus8.o_done === 1'b1 || bus8.o_busy === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        check("mrst_quiet", 64'(ndone), 64'd0);
        do_op("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 8'h00, 1'b0);

        // START held high: back-to-back operations every 9 cycles
        bus8.i_start = 1'b1; bus8.i_a = b2b_a[0]; bus8.i_b = b2b_b[0];
        @(posedge clk); #1;
        for (int op = 0; op < 3; op++) begin
            k = 0;
            do begin
                @(posedge clk); #1;
                k++;
            end while (bus8.o_done !== 1'b1 && k < 30);
            check($sformatf("b2b%0d_gap", op), 64'(k), (op == 0) ? 64'd8 : 64'd9);
            check($sformatf("b2b%0d_s", op), 64'(bus8.o_s), 64'(b2b_s[op]));
            check($sformatf("b2b%0d_cout", op), 64'(bus8.o_cout), 64'(b2b_c[op]));
            if (op < 2) begin
                bus8.i_a = b2b_a[op + 1];
                bus8.i_b = b2b_b[op + 1];
            end else begin
                bus8.i_start = 1'b0;
            end
        end
        @(posedge clk); #1;
        check("b2b_idle_busy", 64'(bus8.o_busy), 64'd0);

`ifdef GTECH_SERIAL_ADD_CIN_EN
        do_op("cin_ff_00", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
`endif

        // WIDTH=1 unit: DONE seen after edge T0+1 (two cycles after START)
        bus1.i_start = 1'b1; bus1.i_a = 1'b1; bus1.i_b = 1'b1;
`ifdef GTECH_SERIAL_ADD_CIN_EN
        bus1.i_cin = 1'b1;
`endif
        @(posedge clk); #1;
        bus1.i_start = 1'b0;
        check("w1_busy", 64'(bus1.o_busy), 64'd1);
        k = 0;
        while (bus1.o_done !== 1'b1 && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        check("w1_done_edges", 64'(k), 64'd1);
`ifdef GTECH_SERIAL_ADD_CIN_EN
        check("w1_s", 64'(bus1.o_s), 64'd1);
`else
        check("w1_s", 64'(bus1.o_s), 64'd0);
`endif
        check("w1_cout", 64'(bus1.o_cout), 64'd1);
        @(posedge clk); #1;
        check("w1_done_pulse", 64'(bus1.o_done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
